mult_wb_arbiter: RTL and testbench

//  Writeback merge stage downstream of the 5-stage pipelined multiplier and the single-cycle ALU.

---
 rtl/mult_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_wb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_wb_arbiter.sv
// Writeback merge of the ALU and the pipelined multiplier onto one
// register-file write port. Multiply results that lose arbitration are held
// in an in-order FIFO; the stage also reports RAW hazards against queued
// multiply destinations and stalls multiply issue before the FIFO can overrun.
module mult_wb_arbiter #(
   parameter int DEPTH        = 8,
   parameter int MULT_LATENCY = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid_i,
   input  logic        alu_rd_wr_en_i,
   input  logic [4:0]  alu_rd_addr_i,
   input  logic [63:0] alu_res_i,
   input  logic        mult_valid_i,
   input  logic        mult_rd_wr_en_i,
   input  logic [4:0]  mult_rd_addr_i,
   input  logic [63:0] mult_res_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic        rf_wr_en_o,
   output logic [4:0]  rf_wr_addr_o,
   output logic [63:0] rf_wr_data_o,
   output logic        mult_stall_o,
   output logic        raw_hazard_o,
   output logic        overflow_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][4:0]  fifo_rd_q;
   logic [DEPTH-1:0][63:0] fifo_data_q;
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   ovf_q;

   logic                   alu_req, mul_req, fifo_ne, fifo_full;
   logic                   sel_v, sel_fifo, sel_byp;
   logic [4:0]             sel_addr;
   logic [63:0]            sel_data;
   logic                   push_req, push, pop, drop;
   logic [DEPTH-1:0]       hit;

   // x0 writes are architecturally void, so they never compete for the port
   assign alu_req   = alu_valid_i & alu_rd_wr_en_i & (alu_rd_addr_i != 5'd0);
   assign mul_req   = mult_valid_i & mult_rd_wr_en_i & (mult_rd_addr_i != 5'd0);
   assign fifo_ne   = (cnt_q != '0);
   assign fifo_full = (cnt_q == CW'(DEPTH));

   assign sel_fifo  = ~alu_req & fifo_ne;
   assign sel_byp   = ~alu_req & ~fifo_ne & mul_req;
   // A multiply that cannot bypass must queue behind older multiplies
   assign push_req  = mul_req & ~sel_byp;
   assign pop       = sel_fifo;
   // A same-cycle pop frees the slot, so only a pop-less push into full drops
   assign drop      = push_req & fifo_full & ~pop;
   assign push      = push_req & ~drop;
   assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

   // Fixed-priority source select: ALU, then FIFO head, then bypassed multiply
   always_comb begin
      sel_v    = 1'b0;
      sel_addr = alu_rd_addr_i;
      sel_data = alu_res_i;
      if (alu_req) begin
         sel_v = 1'b1;
      end else if (fifo_ne) begin
         sel_v    = 1'b1;
         sel_addr = fifo_rd_q[rd_ptr_q];
         sel_data = fifo_data_q[rd_ptr_q];
      end else if (mul_req) begin
         sel_v    = 1'b1;
         sel_addr = mult_rd_addr_i;
         sel_data = mult_res_i;
      end
   end

   // FIFO payload storage; validity is tracked by the pointers and count only
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= mult_rd_addr_i;
         fifo_data_q[wr_ptr_q] <= mult_res_i;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_d;
         if (drop) ovf_q <= 1'b1;
      end
   end

   // Registered write port; address/data hold when nothing is selected
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wr_en_o   <= 1'b0;
         rf_wr_addr_o <= '0;
         rf_wr_data_o <= '0;
      end else begin
         rf_wr_en_o <= sel_v;
         if (sel_v) begin
            rf_wr_addr_o <= sel_addr;
            rf_wr_data_o <= sel_data;
         end
      end
   end

   // Per-slot hazard match; a slot is live if it lies within count of the head
   for (genvar g = 0; g < DEPTH; g++) begin : g_haz
      logic [AW-1:0] off;
      logic          live;
      assign off    = AW'(g) - rd_ptr_q;
      assign live   = ({1'b0, off} < cnt_q);
      assign hit[g] = live &
                      (((rs1_addr_i != 5'd0) && (fifo_rd_q[g] == rs1_addr_i)) ||
                       ((rs2_addr_i != 5'd0) && (fifo_rd_q[g] == rs2_addr_i)));
   end

   assign raw_hazard_o   = |hit;
   // Leaves room for every multiply already in flight when issue is blocked
   assign mult_stall_o   = (cnt_q >= CW'(DEPTH - MULT_LATENCY));
   assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Bench for mult_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the writeback rules.
module tb_mult_wb_arbiter;

   localparam int DEPTH = 8;
   localparam int ML    = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        alu_valid_i = 0, alu_rd_wr_en_i = 0;
   logic [4:0]  alu_rd_addr_i = 0;
   logic [63:0] alu_res_i = 0;
   logic        mult_valid_i = 0, mult_rd_wr_en_i = 0;
   logic [4:0]  mult_rd_addr_i = 0;
   logic [63:0] mult_res_i = 0;
   logic [4:0]  rs1_addr_i = 0, rs2_addr_i = 0;
   logic        rf_wr_en_o, mult_stall_o, raw_hazard_o, overflow_err_o;
   logic [4:0]  rf_wr_addr_o;
   logic [63:0] rf_wr_data_o;

   mult_wb_arbiter #(.DEPTH(DEPTH), .MULT_LATENCY(ML)) dut (
      .clk(clk), .reset(reset),
      .alu_valid_i(alu_valid_i), .alu_rd_wr_en_i(alu_rd_wr_en_i),
      .alu_rd_addr_i(alu_rd_addr_i), .alu_res_i(alu_res_i),
      .mult_valid_i(mult_valid_i), .mult_rd_wr_en_i(mult_rd_wr_en_i),
      .mult_rd_addr_i(mult_rd_addr_i), .mult_res_i(mult_res_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o),
      .rf_wr_data_o(rf_wr_data_o), .mult_stall_o(mult_stall_o),
      .raw_hazard_o(raw_hazard_o), .overflow_err_o(overflow_err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state: pending multiply results in program order, plus port image
   logic [68:0] q[$];
   logic        exp_en = 0, exp_ovf = 0;
   logic [4:0]  exp_addr = 0;
   logic [63:0] exp_data = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz();
      logic h = 1'b0;
      foreach (q[i]) begin
         if (rs1_addr_i != 0 && q[i][68:64] == rs1_addr_i) h = 1'b1;
         if (rs2_addr_i != 0 && q[i][68:64] == rs2_addr_i) h = 1'b1;
      end
      return h;
   endfunction

   task automatic model_push();
      if (q.size() >= DEPTH) exp_ovf = 1'b1;
      else q.push_back({mult_rd_addr_i, mult_res_i});
   endtask

   // one clock: check combinational outputs, advance model, check port
   task automatic step();
      logic areq, mreq;
      logic [68:0] e;
      #1;
      chk("stall", mult_stall_o, q.size() >= DEPTH - ML);
      chk("hazard", raw_hazard_o, model_haz());
      areq = alu_valid_i && alu_rd_wr_en_i && alu_rd_addr_i != 0;
      mreq = mult_valid_i && mult_rd_wr_en_i && mult_rd_addr_i != 0;
      if (areq) begin
         exp_en = 1; exp_addr = alu_rd_addr_i; exp_data = alu_res_i;
         if (mreq) model_push();
      end else if (q.size() != 0) begin
         e = q.pop_front();
         exp_en = 1; exp_addr = e[68:64]; exp_data = e[63:0];
         if (mreq) model_push();
      end else if (mreq) begin
         exp_en = 1; exp_addr = mult_rd_addr_i; exp_data = mult_res_i;
      end else begin
         exp_en = 0;
      end
      @(posedge clk); #1;
      chk("wr_en", rf_wr_en_o, exp_en);
      chk("wr_addr", rf_wr_addr_o, exp_addr);
      chk("wr_data", rf_wr_data_o, exp_data);
      chk("ovf", overflow_err_o, exp_ovf);
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
      alu_valid_i = v; alu_rd_wr_en_i = v; alu_rd_addr_i = rd; alu_res_i = d;
   endtask

   task automatic set_mul(input logic v, input logic [4:0] rd, input logic [63:0] d);
      mult_valid_i = v; mult_rd_wr_en_i = v; mult_rd_addr_i = rd; mult_res_i = d;
   endtask

   task automatic idle();
      set_alu(0, 0, 0); set_mul(0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      exp_en = 0; exp_addr = 0; exp_data = 0; exp_ovf = 0;
      chk("rst_en", rf_wr_en_o, 0);
      chk("rst_addr", rf_wr_addr_o, 0);
      chk("rst_data", rf_wr_data_o, 0);
      chk("rst_ovf", overflow_err_o, 0);
      chk("rst_stall", mult_stall_o, 0);
      chk("rst_haz", raw_hazard_o, 0);
   endtask

   initial begin
      do_reset();

      // lone multiply bypasses straight to the port
      idle(); set_mul(1, 3, 64'h1234); step();
      idle(); step();

      // ALU and multiply collide: ALU first, multiply next cycle
      set_alu(1, 5, 64'h55); set_mul(1, 6, 64'h66); step();
      idle(); step(); step();

      // ordering with ALU busy for three cycles, hazard on rs1=2
      rs1_addr_i = 2;
      set_alu(1, 10, 64'hA0); set_mul(1, 1, 64'h11); step();
      set_alu(1, 11, 64'hA1); set_mul(1, 2, 64'h22); step();
      set_alu(1, 12, 64'hA2); set_mul(1, 3, 64'h33); step();
      idle(); step(); step(); step(); step();
      rs1_addr_i = 0;

      // fill to threshold, then overflow on the 9th queued result
      for (int i = 0; i < 9; i++) begin
         set_alu(1, 5'(20 + i), 64'(i)); set_mul(1, 5'(1 + i), 64'(100 + i));
         step();
      end
      idle();
      for (int i = 0; i < 10; i++) step();

      // x0 filtering
      rs1_addr_i = 0; rs2_addr_i = 0;
      set_alu(1, 0, 64'hDEAD); set_mul(1, 0, 64'hBEEF); step();
      idle(); step();

      // reset with four entries queued
      for (int i = 0; i < 4; i++) begin
         set_alu(1, 9, 64'(i)); set_mul(1, 5'(4 + i), 64'(i));
         step();
      end
      rs1_addr_i = 5; idle();
      do_reset();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         alu_valid_i     = ($urandom_range(0, 9) < 6);
         alu_rd_wr_en_i  = ($urandom_range(0, 7) != 0);
         alu_rd_addr_i   = 5'($urandom_range(0, 7));
         alu_res_i       = {$urandom, $urandom};
         mult_valid_i    = ($urandom_range(0, 9) < 5);
         mult_rd_wr_en_i = ($urandom_range(0, 7) != 0);
         mult_rd_addr_i  = 5'($urandom_range(0, 7));
         mult_res_i      = {$urandom, $urandom};
         rs1_addr_i      = 5'($urandom_range(0, 7));
         rs2_addr_i      = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) do_reset();
         else step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
